// File: rtl/lc3_pkg.sv
// Shared LC-3 constants and the debug-dump FSM state encoding.
// The debug UART framer reuses the state typedef to decode dump progress.
package lc3_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int WORD_W     = 16;
  localparam int NUM_REGS   = 8;

  typedef enum logic [2:0] {
    DUMP_IDLE    = 3'd0,
    DUMP_ISSUE   = 3'd1,
    DUMP_CAPTURE = 3'd2,
    DUMP_SEND    = 3'd3,
    DUMP_DONE    = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping range of the register file through its registered SR1 port
// and streams each value out over valid/ready, one register per three cycles.
module regfile_dump_reader
  import lc3_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_done
);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  // Beats still owed after the current one; zero marks the final register.
  logic [ADDR_W-1:0] remaining;

  // Dump sequencer: all outputs are registered here.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state     <= DUMP_IDLE;
      idx       <= '0;
      remaining <= '0;
      o_busy    <= 1'b0;
      o_rf_addr <= '0;
      o_data    <= '0;
      o_idx     <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          o_busy <= 1'b0;
          if (i_start) begin
            idx       <= i_first_addr;
            o_rf_addr <= i_first_addr;
            // Modular subtract lets last<first wrap through the top register.
            remaining <= i_last_addr - i_first_addr;
            o_busy    <= 1'b1;
            state     <= DUMP_ISSUE;
          end
        end
        DUMP_ISSUE: begin
          // Register file samples o_rf_addr on this edge; data lands next cycle.
          state <= DUMP_CAPTURE;
        end
        DUMP_CAPTURE: begin
          o_data  <= i_rf_data;
          o_idx   <= idx;
          o_last  <= (remaining == '0);
          o_valid <= 1'b1;
          state   <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (o_last) begin
              o_done <= 1'b1;
              state  <= DUMP_DONE;
            end else begin
              idx       <= idx + ADDR_W'(1);
              o_rf_addr <= idx + ADDR_W'(1);
              remaining <= remaining - ADDR_W'(1);
              state     <= DUMP_ISSUE;
            end
          end
        end
        DUMP_DONE: begin
          o_busy <= 1'b0;
          state  <= DUMP_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          state   <= DUMP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: registered-read RF model plus a queue-based expectation
// of which registers a dump should emit and when.
module tb_regfile_dump_reader;

  logic        clk;
  logic        i_RST;
  logic        i_start;
  logic [2:0]  i_first_addr;
  logic [2:0]  i_last_addr;
  logic        o_busy;
  logic [2:0]  o_rf_addr;
  logic [15:0] i_rf_data;
  logic [15:0] o_data;
  logic [2:0]  o_idx;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [15:0] regs [8];

  logic [2:0]  q_idx [$];
  logic [15:0] q_data [$];
  logic        q_last [$];
  int          q_cyc [$];
  int          busy_n, busy_first, busy_last, done_n, done_cyc;

  regfile_dump_reader #(.ADDR_W(3), .DATA_W(16)) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_start(i_start),
    .i_first_addr(i_first_addr), .i_last_addr(i_last_addr),
    .o_busy(o_busy), .o_rf_addr(o_rf_addr), .i_rf_data(i_rf_data),
    .o_data(o_data), .o_idx(o_idx), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model with a one-cycle registered read.
  always @(posedge clk) i_rf_data <= regs[o_rf_addr];

  function automatic int beats_for(input int first, input int last);
    return ((last - first + 8) % 8) + 1;
  endfunction

  function automatic logic [2:0] reg_at(input int first, input int k);
    return 3'((first + k) % 8);
  endfunction

  task automatic fill_regs(input bit rnd);
    for (int i = 0; i < 8; i++) regs[i] = rnd ? 16'($urandom) : (16'hA000 + 16'(i));
  endtask

  task automatic clear_log();
    q_idx.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
    busy_n = 0; busy_first = -1; busy_last = -1; done_n = 0; done_cyc = -1;
  endtask

  task automatic sample_cycle();
    int rel;
    rel = cyc - start_cyc;
    if (o_valid && i_ready) begin
      q_idx.push_back(o_idx); q_data.push_back(o_data);
      q_last.push_back(o_last); q_cyc.push_back(rel);
    end
    if (o_busy) begin
      busy_n++;
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (o_done) begin
      done_n++; done_cyc = rel;
    end
  endtask

  // Called just after a rising edge; that cycle becomes cycle 0.
  task automatic start_dump(input int first, input int last);
    clear_log();
    i_first_addr = 3'(first);
    i_last_addr  = 3'(last);
    i_start      = 1'b1;
    start_cyc    = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      sample_cycle();
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rnd) i_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset();
    i_RST = 1'b1; i_start = 1'b0; i_ready = 1'b0;
    i_first_addr = 3'd0; i_last_addr = 3'd0;
    fill_regs(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b valid=%b last=%b done=%b, required all 0", o_busy, o_valid, o_last, o_done);
    end
    checks++;
    if (o_data !== 16'h0 || o_idx !== 3'd0 || o_rf_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: data=%h idx=%0d rf_addr=%0d, required 0", o_data, o_idx, o_rf_addr);
    end
    @(posedge clk); #1;
    i_RST = 1'b0;
  endtask

  task automatic test_full_range();
    bit ok;
    @(posedge clk); #1;
    fill_regs(1'b0);
    i_ready = 1'b1;
    start_dump(0, 7);
    wait_done(100, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: no o_done within 100 cycles"); end
    checks++;
    if (q_idx.size() != 8) begin errors++; $display("FAIL full_count: got %0d beats, required 8", q_idx.size()); end
    for (int k = 0; k < 8 && k < q_idx.size(); k++) begin
      checks++;
      if (q_idx[k] !== reg_at(0, k) || q_data[k] !== 16'hA000 + 16'(k) || q_last[k] !== (k == 7) || q_cyc[k] != 3 * k + 3) begin
        errors++;
        $display("FAIL full_beat%0d: idx=%0d data=%h last=%b cyc=%0d, required idx=%0d data=%h last=%b cyc=%0d",
                 k, q_idx[k], q_data[k], q_last[k], q_cyc[k], k, 16'hA000 + 16'(k), (k == 7), 3 * k + 3);
      end
    end
    checks++;
    if (done_n != 1 || done_cyc != 25) begin
      errors++; $display("FAIL full_done: pulses=%0d at cycle %0d, required 1 at 25", done_n, done_cyc);
    end
    checks++;
    if (busy_first != 1 || busy_last != 25 || busy_n != 25) begin
      errors++; $display("FAIL full_busy: cycles %0d..%0d n=%0d, required 1..25 n=25", busy_first, busy_last, busy_n);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL full_busy_drop: busy=%b at cycle 26, required 0", o_busy); end
  endtask

  task automatic test_wrap_range();
    bit ok;
    @(posedge clk); #1;
    i_ready = 1'b1;
    start_dump(6, 1);
    wait_done(100, 1'b0, ok);
    checks++;
    if (!ok || q_idx.size() != 4) begin
      errors++; $display("FAIL wrap_count: done=%b beats=%0d, required done with 4 beats", ok, q_idx.size());
    end
    for (int k = 0; k < 4 && k < q_idx.size(); k++) begin
      checks++;
      if (q_idx[k] !== reg_at(6, k) || q_data[k] !== regs[reg_at(6, k)] || q_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL wrap_beat%0d: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                 k, q_idx[k], q_data[k], q_last[k], reg_at(6, k), regs[reg_at(6, k)], (k == 3));
      end
    end
  endtask

  task automatic test_single_beat();
    bit ok;
    @(posedge clk); #1;
    i_ready = 1'b1;
    start_dump(5, 5);
    wait_done(100, 1'b0, ok);
    checks++;
    if (!ok || q_idx.size() != 1) begin
      errors++; $display("FAIL single_count: done=%b beats=%0d, required done with 1 beat", ok, q_idx.size());
    end else begin
      checks++;
      if (q_idx[0] !== 3'd5 || q_data[0] !== 16'hA005 || q_last[0] !== 1'b1) begin
        errors++; $display("FAIL single_beat: idx=%0d data=%h last=%b, required 5 A005 1", q_idx[0], q_data[0], q_last[0]);
      end
      checks++;
      if (done_cyc != q_cyc[0] + 1) begin
        errors++; $display("FAIL single_done: done at %0d, required %0d", done_cyc, q_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    @(posedge clk); #1;
    i_ready = 1'b0;
    start_dump(2, 3);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      sample_cycle();
      if (o_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_first_valid: o_valid never rose within 10 cycles"); end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin @(negedge clk); sample_cycle(); end
      checks++;
      if (o_valid !== 1'b1 || o_data !== 16'hA002 || o_idx !== 3'd2 || o_rf_addr !== 3'd2) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h idx=%0d rf_addr=%0d, required 1 A002 2 2", s, o_valid, o_data, o_idx, o_rf_addr);
      end
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    wait_done(50, 1'b0, ok);
    checks++;
    if (!ok || q_idx.size() != 2) begin
      errors++; $display("FAIL bp_count: done=%b beats=%0d, required done with 2 beats", ok, q_idx.size());
    end else begin
      checks++;
      if (q_cyc[0] != 8 || q_cyc[1] != 11 || q_idx[1] !== 3'd3 || q_data[1] !== 16'hA003) begin
        errors++;
        $display("FAIL bp_second: hs cycles %0d,%0d idx=%0d data=%h, required 8,11 idx=3 data=A003", q_cyc[0], q_cyc[1], q_idx[1], q_data[1]);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int rel;
    @(posedge clk); #1;
    i_ready = 1'b1;
    start_dump(1, 3);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sample_cycle();
      if (o_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      rel = cyc - start_cyc;
      i_start = (rel == 2 || rel == 6 || rel == 10);
      i_first_addr = 3'd6; i_last_addr = 3'd0;
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); sample_cycle(); @(posedge clk); #1; end
    checks++;
    if (!ok || q_idx.size() != 3 || done_n != 1 || busy_n != 10) begin
      errors++;
      $display("FAIL restart_ignored: done=%b beats=%0d dones=%0d busy_cycles=%0d, required 1 3 1 10", ok, q_idx.size(), done_n, busy_n);
    end
    for (int k = 0; k < 3 && k < q_idx.size(); k++) begin
      checks++;
      if (q_idx[k] !== reg_at(1, k) || q_data[k] !== regs[reg_at(1, k)]) begin
        errors++; $display("FAIL restart_beat%0d: idx=%0d data=%h, required idx=%0d data=%h", k, q_idx[k], q_data[k], reg_at(1, k), regs[reg_at(1, k)]);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    bit hit;
    @(posedge clk); #1;
    i_ready = 1'b1;
    start_dump(2, 6);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      sample_cycle();
      if (o_valid && o_idx == 3'd4) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_reach_idx4: beat idx 4 never appeared"); end
    i_RST = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_rf_addr !== 3'd0) begin
      errors++; $display("FAIL rst_abort: valid=%b busy=%b rf_addr=%0d, required 0 0 0", o_valid, o_busy, o_rf_addr);
    end
    @(posedge clk); #1;
    i_RST = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); sample_cycle(); @(posedge clk); #1; end
    checks++;
    if (done_n != 0 || q_idx.size() != 3) begin
      errors++; $display("FAIL rst_no_done: dones=%0d beats=%0d, required 0 dones and 3 beats", done_n, q_idx.size());
    end
    start_dump(0, 0);
    wait_done(50, 1'b0, ok);
    checks++;
    if (!ok || q_idx.size() != 1 || q_data[0] !== 16'hA000 || q_idx[0] !== 3'd0 || q_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_fresh: done=%b beats=%0d data=%h, required one last beat idx 0 data A000", ok, q_idx.size(), q_data.size() > 0 ? q_data[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random_dumps();
    bit ok;
    int first, last, n;
    for (int it = 0; it < 25; it++) begin
      @(posedge clk); #1;
      fill_regs(1'b1);
      first = $urandom_range(0, 7);
      last  = $urandom_range(0, 7);
      n = beats_for(first, last);
      i_ready = ($urandom_range(0, 3) != 0);
      start_dump(first, last);
      wait_done(300, 1'b1, ok);
      checks++;
      if (!ok || q_idx.size() != n || done_n != 1) begin
        errors++;
        $display("FAIL rand%0d_count: done=%b beats=%0d dones=%0d, required %0d beats one done (first=%0d last=%0d)", it, ok, q_idx.size(), done_n, n, first, last);
      end
      for (int k = 0; k < n && k < q_idx.size(); k++) begin
        checks++;
        if (q_idx[k] !== reg_at(first, k) || q_data[k] !== regs[reg_at(first, k)] || q_last[k] !== (k == n - 1)) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                   it, k, q_idx[k], q_data[k], q_last[k], reg_at(first, k), regs[reg_at(first, k)], (k == n - 1));
        end
      end
      if (q_cyc.size() > 0) begin
        checks++;
        if (done_cyc != q_cyc[q_cyc.size() - 1] + 1 || busy_last != done_cyc) begin
          errors++;
          $display("FAIL rand%0d_done_timing: done=%0d busy_last=%0d, required both %0d", it, done_cyc, busy_last, q_cyc[q_cyc.size() - 1] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_range();
    test_wrap_range();
    test_single_beat();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_dump();
    test_random_dumps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
